bcd_counter_n: RTL and testbench

BCD_COUNTER_N -- requirements
Module: bcd_counter_n

---
 rtl/bcd_counter_n.sv | 90 +++++++++
 tb/tb_bcd_counter_n.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/bcd_counter_n.sv
// Multi-digit BCD up/down counter with validated parallel load, ripple-carry
// terminal flag, sticky overflow and a load-error pulse.
module bcd_counter_n #(
  parameter int DIGITS = 4,
  parameter bit SAT    = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data,
  input  logic                  clr_ovr,
  output logic [4*DIGITS-1:0]   count,
  output logic                  RCO,
  output logic                  ovr,
  output logic                  load_err
);

  localparam int W = 4 * DIGITS;

  logic [W-1:0]    count_inc;
  logic [W-1:0]    count_dec;
  logic [DIGITS:0] carry;
  logic [DIGITS:0] borrow;
  logic            all_nine;
  logic            all_zero;
  logic            data_ok;

  // Digit-serial carry/borrow chains; a digit only moves when the chain reaches it.
  always_comb begin
    count_inc = count;
    count_dec = count;
    carry     = '0;
    borrow    = '0;
    carry[0]  = 1'b1;
    borrow[0] = 1'b1;
    all_nine  = 1'b1;
    all_zero  = 1'b1;
    data_ok   = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (count[4*i +: 4] != 4'd9) all_nine = 1'b0;
      if (count[4*i +: 4] != 4'd0) all_zero = 1'b0;
      if (data[4*i +: 4] > 4'd9)   data_ok  = 1'b0;

      if (carry[i]) begin
        if (count[4*i +: 4] >= 4'd9) begin
          count_inc[4*i +: 4] = 4'd0;
          carry[i+1]          = 1'b1;
        end else begin
          count_inc[4*i +: 4] = count[4*i +: 4] + 4'd1;
        end
      end

      if (borrow[i]) begin
        if (count[4*i +: 4] == 4'd0) begin
          count_dec[4*i +: 4] = 4'd9;
          borrow[i+1]         = 1'b1;
        end else if (count[4*i +: 4] > 4'd9) begin
          count_dec[4*i +: 4] = 4'd9;
        end else begin
          count_dec[4*i +: 4] = count[4*i +: 4] - 4'd1;
        end
      end
    end
  end

  assign RCO = enable & ~load & (up ? all_nine : all_zero);

  always_ff @(posedge clk) begin
    if (reset) begin
      count    <= '0;
      ovr      <= 1'b0;
      load_err <= 1'b0;
    end else begin
      load_err <= load & ~data_ok;

      if (load) begin
        if (data_ok) count <= data;
      end else if (enable) begin
        // In saturate mode a terminal step leaves the count parked at its limit.
        if (!(SAT && RCO)) count <= up ? count_inc : count_dec;
      end

      if (RCO)          ovr <= 1'b1;
      else if (clr_ovr) ovr <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bcd_counter_n.sv
// Directed bench for bcd_counter_n: a wrap-mode and a saturate-mode instance
// share one stimulus stream and are checked against hand-computed values.
module tb_bcd_counter_n;

  logic        clk = 1'b0;
  logic        reset, enable, up, load, clr_ovr;
  logic [15:0] data;
  logic [15:0] count0, count1;
  logic        rco0, rco1, ovr0, ovr1, lerr0, lerr1;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bcd_counter_n #(.DIGITS(4), .SAT(1'b0)) u_wrap (
    .clk(clk), .reset(reset), .enable(enable), .up(up), .load(load),
    .data(data), .clr_ovr(clr_ovr), .count(count0), .RCO(rco0),
    .ovr(ovr0), .load_err(lerr0)
  );

  bcd_counter_n #(.DIGITS(4), .SAT(1'b1)) u_sat (
    .clk(clk), .reset(reset), .enable(enable), .up(up), .load(load),
    .data(data), .clr_ovr(clr_ovr), .count(count1), .RCO(rco1),
    .ovr(ovr1), .load_err(lerr1)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; up = 1'b1; load = 1'b0; clr_ovr = 1'b0; data = 16'h0000;
    tick();
    chk("reset_count", count0, 16'h0000);
    chk("reset_ovr", ovr0, 1'b0);
    chk("reset_lerr", lerr0, 1'b0);
    chk("reset_rco_idle", rco0, 1'b0);

    // Post-reset RCO for down-counting from zero
    enable = 1'b1; up = 1'b0; #1;
    chk("reset_rco_down", rco0, 1'b1);
    tick();
    chk("reset_override", count0, 16'h0000);
    chk("reset_override_ovr", ovr0, 1'b0);

    up = 1'b1; reset = 1'b0;
    repeat (10) tick();
    chk("inc_10", count0, 16'h0010);
    repeat (90) tick();
    chk("inc_100", count0, 16'h0100);
    chk("inc_100_sat", count1, 16'h0100);
    chk("inc_no_ovr", ovr0, 1'b0);

    // Rejected load, then accepted load with enable low
    load = 1'b1; data = 16'h12A4; tick();
    chk("bad_load_count", count0, 16'h0100);
    chk("bad_load_err", lerr0, 1'b1);
    load = 1'b0; enable = 1'b0; tick();
    chk("bad_load_err_pulse", lerr0, 1'b0);
    chk("hold_count", count0, 16'h0100);
    load = 1'b1; data = 16'hA000; tick();
    chk("bad_top_digit", count0, 16'h0100);
    chk("bad_top_err", lerr0, 1'b1);
    data = 16'h1234; tick();
    chk("good_load", count0, 16'h1234);
    chk("good_load_err", lerr0, 1'b0);

    // Up terminal step: wrap vs saturate
    data = 16'h9999; tick();
    load = 1'b0; enable = 1'b1; up = 1'b1; #1;
    chk("rco_up_wrap", rco0, 1'b1);
    chk("rco_up_sat", rco1, 1'b1);
    tick();
    chk("wrap_up_count", count0, 16'h0000);
    chk("wrap_up_ovr", ovr0, 1'b1);
    chk("sat_up_count", count1, 16'h9999);
    chk("sat_up_ovr", ovr1, 1'b1);

    // clr_ovr racing a terminal step (wrap) vs clr_ovr alone (sat)
    up = 1'b0; clr_ovr = 1'b1; #1;
    chk("rco_down_wrap", rco0, 1'b1);
    chk("rco_down_sat_off", rco1, 1'b0);
    tick();
    chk("wrap_down_count", count0, 16'h9999);
    chk("clr_vs_term_ovr", ovr0, 1'b1);
    chk("clr_alone_ovr", ovr1, 1'b0);
    enable = 1'b0; tick();
    chk("clr_ovr_cleared", ovr0, 1'b0);
    clr_ovr = 1'b0;

    // Down terminal step in saturate mode
    load = 1'b1; data = 16'h0000; tick();
    load = 1'b0; enable = 1'b1; up = 1'b0; #1;
    chk("rco_zero_sat", rco1, 1'b1);
    tick();
    chk("sat_down_count", count1, 16'h0000);
    chk("sat_down_ovr", ovr1, 1'b1);
    chk("wrap_down2_count", count0, 16'h9999);

    // Borrow across several digits
    load = 1'b1; data = 16'h1000; tick();
    load = 1'b0; tick();
    chk("borrow_chain", count0, 16'h0999);

    // Direction toggling every cycle
    load = 1'b1; data = 16'h0500; tick();
    load = 1'b0; up = 1'b1; tick();
    chk("toggle_1", count0, 16'h0501);
    up = 1'b0; tick();
    chk("toggle_2", count0, 16'h0500);
    up = 1'b1; tick();
    chk("toggle_3", count0, 16'h0501);
    up = 1'b0; tick();
    chk("toggle_4", count0, 16'h0500);
    up = 1'b1; reset = 1'b1; tick();
    chk("mid_reset_count", count0, 16'h0000);
    chk("mid_reset_ovr", ovr1, 1'b0);
    reset = 1'b0; tick();
    chk("resume_after_reset", count0, 16'h0001);
    enable = 1'b0; tick();
    chk("hold_after_resume", count0, 16'h0001);

    // Load wins over enabled counting
    enable = 1'b1; load = 1'b1; data = 16'h4321; #1;
    chk("rco_masked_by_load", rco0, 1'b0);
    tick();
    chk("load_over_count", count0, 16'h4321);
    load = 1'b0; tick();
    chk("count_after_load", count0, 16'h4322);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
